// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | dmem_arb_pkg : shared types and constants for the data-memory arbiter
// | Revision     : 1.0
// +----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      GNT_P = 1'b0,
      GNT_L = 1'b1
   } gnt_e;

   localparam int DEFAULT_LAT = 2;

   // A one-cycle memory still needs a 1-bit counter.
   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | dmem_rr_arbiter : two-way round-robin arbiter, bit 0 = pipeline, bit 1 = loader
// | Revision        : 1.0
// +----------------------------------------------------------------------------
module dmem_rr_arbiter
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  gnt_e       i_last,
   output logic [1:0] o_gnt,
   output logic       o_gnt_valid
);

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         // On a tie the requester that did not win last time goes first.
         2'b11:   o_gnt = (i_last == GNT_L) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   assign o_gnt_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | dmem_arbiter : shares the single-port MEM-stage data memory between the
// |                pipeline and the loader, one fixed-latency access at a time
// | Revision     : 1.0
// +----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int LAT = DEFAULT_LAT,
   parameter int AW  = 32,
   parameter int DW  = 32
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          p_req,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic [DW-1:0] p_rdata,
   output logic          p_done,
   output logic          p_stall,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic [DW-1:0] l_rdata,
   output logic          l_done,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   output logic          m_write,
   output logic          m_read,
   input  logic [DW-1:0] m_rdata,
   output logic          busy
);

   localparam int            CW       = cnt_width(LAT);
   localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

   state_e        r_state;
   gnt_e          r_last;
   gnt_e          r_gnt;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_we;
   logic [DW-1:0] r_p_rdata;
   logic [DW-1:0] r_l_rdata;

   logic [1:0]    w_gnt;
   logic          w_gnt_valid;
   logic          w_access;
   logic          w_last_cycle;

   dmem_rr_arbiter u_rr (
      .i_req       ({l_req, p_req}),
      .i_last      (r_last),
      .o_gnt       (w_gnt),
      .o_gnt_valid (w_gnt_valid)
   );

   assign w_access     = (r_state == ACCESS);
   assign w_last_cycle = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last    <= GNT_L;
         r_gnt     <= GNT_P;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_we      <= 1'b0;
         r_p_rdata <= '0;
         r_l_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_valid) begin
                  r_state <= ACCESS;
                  r_cnt   <= '0;
                  if (w_gnt[0]) begin
                     r_gnt   <= GNT_P;
                     r_last  <= GNT_P;
                     r_addr  <= p_addr;
                     r_wdata <= p_wdata;
                     r_we    <= p_we;
                  end else if (w_gnt[1]) begin
                     r_gnt   <= GNT_L;
                     r_last  <= GNT_L;
                     r_addr  <= l_addr;
                     r_wdata <= l_wdata;
                     r_we    <= l_we;
                  end
               end
            end
            ACCESS: begin
               if (w_last_cycle) begin
                  r_state <= DONE;
                  r_cnt   <= '0;
                  // Read data is only valid on the final access cycle.
                  if (!r_we) begin
                     if (r_gnt == GNT_P) r_p_rdata <= m_rdata;
                     else                r_l_rdata <= m_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign m_addr  = w_access ? r_addr  : '0;
   assign m_wdata = w_access ? r_wdata : '0;
   assign m_write = w_access & r_we & (r_cnt == '0);
   assign m_read  = w_access & ~r_we;
   assign busy    = (r_state != IDLE);

   assign p_done  = (r_state == DONE) & (r_gnt == GNT_P);
   assign l_done  = (r_state == DONE) & (r_gnt == GNT_L);
   assign p_rdata = r_p_rdata;
   assign l_rdata = r_l_rdata;
   assign p_stall = p_req & ~p_done;

endmodule
`default_nettype wire
